// File: rtl/tag_out_reg.sv
// Read-side register stage for the tag sorter: launches a min-tag search, holds the result
// under valid/ready, then pulses a delete. Optional search timeout via TAG_OUT_TIMEOUT_EN.
module tag_out_reg #(
    parameter int unsigned TAG_W   = 12,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_deq_en,
    input  logic             i_tree_empty,
    output logic             o_search_start,
    input  logic             i_search_done,
    input  logic [TAG_W-1:0] i_search_tag,
    output logic             o_tag_delete,
    output logic [TAG_W-1:0] o_tag_out,
    output logic             o_tag_valid,
    input  logic             i_tag_ready,
    output logic             o_underflow,
    output logic [CNT_W-1:0] o_deq_count,
    output logic             o_err
);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e           r_state;
    logic             r_search_start;
    logic             r_tag_delete;
    logic             r_underflow;
    logic             r_tag_valid;
    logic [TAG_W-1:0] r_tag_out;
    logic [CNT_W-1:0] r_deq_count;
    logic             w_done_ok;

    // A done pulse coinciding with our own start pulse is stale and must not be captured.
    assign w_done_ok = (r_state == StWait) && i_search_done && !r_search_start;

`ifdef TAG_OUT_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT) + 1;

    logic [TmoW-1:0] r_tmo_cnt;
    logic            r_err;
    logic            w_tmo;

    assign w_tmo = (r_tmo_cnt == TmoW'(TIMEOUT - 1));
    assign o_err = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = |TIMEOUT;
    assign o_err            = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_search_start <= 1'b0;
            r_tag_delete   <= 1'b0;
            r_underflow    <= 1'b0;
            r_tag_valid    <= 1'b0;
            r_tag_out      <= '0;
            r_deq_count    <= '0;
`ifdef TAG_OUT_TIMEOUT_EN
            r_tmo_cnt      <= '0;
            r_err          <= 1'b0;
`endif
        end else begin
            r_search_start <= 1'b0;
            r_tag_delete   <= 1'b0;
            r_underflow    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_deq_en) begin
                        if (!i_tree_empty) begin
                            r_search_start <= 1'b1;
                            r_state        <= StWait;
`ifdef TAG_OUT_TIMEOUT_EN
                            r_tmo_cnt      <= '0;
`endif
                        end else begin
                            r_underflow <= 1'b1;
                        end
                    end
                end
                StWait: begin
`ifdef TAG_OUT_TIMEOUT_EN
                    r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
`endif
                    if (w_done_ok) begin
                        r_tag_out   <= i_search_tag;
                        r_tag_valid <= 1'b1;
                        r_state     <= StHold;
                    end
`ifdef TAG_OUT_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_state <= StIdle;
                        r_err   <= 1'b1;
                    end
`endif
                end
                StHold: begin
                    // Always back to IDLE so the tree sees the delete before the next search.
                    if (i_tag_ready) begin
                        r_tag_valid  <= 1'b0;
                        r_tag_delete <= 1'b1;
                        r_deq_count  <= r_deq_count + CNT_W'(1);
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_search_start = r_search_start;
    assign o_tag_delete   = r_tag_delete;
    assign o_underflow    = r_underflow;
    assign o_tag_valid    = r_tag_valid;
    assign o_tag_out      = r_tag_out;
    assign o_deq_count    = r_deq_count;

endmodule

// File: tb/tb_tag_out_reg.sv
// Bench for tag_out_reg: transaction-level model checked every cycle, plus directed literal checks.
module tb_tag_out_reg;

    localparam int unsigned TAG_W   = 12;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 32;

    logic             clk          = 1'b0;
    logic             rst          = 1'b1;
    logic             deq_en       = 1'b0;
    logic             tree_empty   = 1'b1;
    logic             search_done  = 1'b0;
    logic [TAG_W-1:0] search_tag   = '0;
    logic             tag_ready    = 1'b0;
    logic             search_start;
    logic             tag_delete;
    logic [TAG_W-1:0] tag_out;
    logic             tag_valid;
    logic             underflow;
    logic [CNT_W-1:0] deq_count;
    logic             err;

    int n_vec  = 0;
    int n_fail = 0;

    tag_out_reg #(
        .TAG_W  (TAG_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_deq_en      (deq_en),
        .i_tree_empty  (tree_empty),
        .o_search_start(search_start),
        .i_search_done (search_done),
        .i_search_tag  (search_tag),
        .o_tag_delete  (tag_delete),
        .o_tag_out     (tag_out),
        .o_tag_valid   (tag_valid),
        .i_tag_ready   (tag_ready),
        .o_underflow   (underflow),
        .o_deq_count   (deq_count),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle, 1=search outstanding, 2=tag held.
    int               m_mode = 0;
    int               m_wcyc = 0;
    bit               m_on   = 1'b0;
    bit               m_was_start;
    logic             m_start, m_del, m_uf, m_valid, m_err;
    logic [TAG_W-1:0] m_tag;
    logic [CNT_W-1:0] m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1'b1; m_mode = 0; m_wcyc = 0;
            m_start = 0; m_del = 0; m_uf = 0; m_valid = 0; m_err = 0; m_tag = '0; m_cnt = '0;
        end else if (m_on) begin
            m_was_start = m_start;
            m_start = 0; m_del = 0; m_uf = 0;
            if (m_mode == 0) begin
                if (deq_en && !tree_empty) begin
                    m_start = 1; m_mode = 1; m_wcyc = 0;
                end else if (deq_en) begin
                    m_uf = 1;
                end
            end else if (m_mode == 1) begin
                m_wcyc++;
                if (search_done && !m_was_start) begin
                    m_tag = search_tag; m_valid = 1; m_mode = 2;
                end
`ifdef TAG_OUT_TIMEOUT_EN
                else if (m_wcyc == TIMEOUT) begin
                    m_mode = 0; m_err = 1;
                end
`endif
            end else if (tag_ready) begin
                m_valid = 0; m_del = 1; m_cnt = m_cnt + 1'b1; m_mode = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("model_search_start", 32'(search_start), 32'(m_start));
            chk("model_tag_delete", 32'(tag_delete), 32'(m_del));
            chk("model_underflow", 32'(underflow), 32'(m_uf));
            chk("model_tag_valid", 32'(tag_valid), 32'(m_valid));
            chk("model_tag_out", 32'(tag_out), 32'(m_tag));
            chk("model_deq_count", 32'(deq_count), 32'(m_cnt));
            chk("model_err", 32'(err), 32'(m_err));
        end
    end

    // Request a search; returns at the negedge where search_start is first seen high.
    task automatic start_search();
        bit seen = 1'b0;
        deq_en     = 1'b1;
        tree_empty = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (search_start === 1'b1) seen = 1'b1;
            deq_en = 1'b0;
        end
        chk("search_start_seen", 32'(seen), 32'd1);
    endtask

    task automatic answer(input logic [TAG_W-1:0] tag, input int delay);
        repeat (delay) @(negedge clk);
        search_done = 1'b1;
        search_tag  = tag;
        @(negedge clk);
        search_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_tag_valid", 32'(tag_valid), 32'd0);
        chk("rst_tag_out", 32'(tag_out), 32'd0);
        chk("rst_deq_count", 32'(deq_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Fast path: tree answers one cycle after start, downstream always ready.
        tag_ready = 1'b1;
        start_search();
        answer(12'h3A5, 1);
        chk("fast_valid", 32'(tag_valid), 32'd1);
        chk("fast_tag", 32'(tag_out), 32'h3A5);
        @(negedge clk);
        chk("fast_valid_drop", 32'(tag_valid), 32'd0);
        chk("fast_delete", 32'(tag_delete), 32'd1);
        chk("fast_count", 32'(deq_count), 32'd1);
        chk("fast_tag_kept", 32'(tag_out), 32'h3A5);
        @(negedge clk);
        chk("fast_delete_once", 32'(tag_delete), 32'd0);

        // Backpressure: hold for 10 cycles.
        tag_ready = 1'b0;
        start_search();
        answer(12'h3A5, 1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(tag_valid), 32'd1);
            chk("hold_tag", 32'(tag_out), 32'h3A5);
            chk("hold_no_delete", 32'(tag_delete), 32'd0);
            @(negedge clk);
        end
        tag_ready = 1'b1;
        @(negedge clk);
        chk("hold_delete", 32'(tag_delete), 32'd1);
        chk("hold_count", 32'(deq_count), 32'd2);

        // Underflow: empty tree with deq_en for three cycles.
        tree_empty = 1'b1;
        deq_en     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("uf_pulse", 32'(underflow), 32'd1);
            chk("uf_no_start", 32'(search_start), 32'd0);
        end
        deq_en = 1'b0;
        @(negedge clk);
        chk("uf_clear", 32'(underflow), 32'd0);

        // Reset during WAIT; a late search_done must be ignored.
        start_search();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        answer(12'h0FF, 0);
        @(negedge clk);
        chk("rstwait_valid", 32'(tag_valid), 32'd0);
        chk("rstwait_tag", 32'(tag_out), 32'd0);
        chk("rstwait_count", 32'(deq_count), 32'd0);

        // Withheld search_done.
        start_search();
`ifdef TAG_OUT_TIMEOUT_EN
        repeat (31) @(negedge clk);
        chk("tmo_err_before", 32'(err), 32'd0);
        @(negedge clk);
        chk("tmo_err_set", 32'(err), 32'd1);
        start_search();
        answer(12'h5C3, 1);
        chk("tmo_after_valid", 32'(tag_valid), 32'd1);
        chk("tmo_after_tag", 32'(tag_out), 32'h5C3);
        @(negedge clk);
        chk("tmo_err_sticky", 32'(err), 32'd1);
        chk("tmo_after_count", 32'(deq_count), 32'd1);
`else
        repeat (40) @(negedge clk);
        chk("wait_no_err", 32'(err), 32'd0);
        chk("wait_no_valid", 32'(tag_valid), 32'd0);
        answer(12'h5C3, 0);
        chk("wait_late_valid", 32'(tag_valid), 32'd1);
        chk("wait_late_tag", 32'(tag_out), 32'h5C3);
        @(negedge clk);
        chk("wait_late_delete", 32'(tag_delete), 32'd1);
        chk("wait_late_count", 32'(deq_count), 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
